// File: rtl/ow_responder.sv
// One-wire responder (device side). Answers master reset pulses with a
// presence pulse, decodes write slots into bytes and drives read slots from
// a loaded transmit byte. The bus is only ever pulled low or released.
module ow_responder #(
  parameter int CNT_W     = 16,
  parameter int RST_MIN   = 480,
  parameter int PRES_DLY  = 30,
  parameter int PRES_LEN  = 120,
  parameter int SAMPLE_PT = 30,
  parameter int RD_HOLD   = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  inout  wire        bus,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       tx_done,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       reset_seen,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, SLOT, WAIT_HIGH, PRES_WAIT, PRES_DRIVE, PRES_END
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] RST_MIN_C   = CNT_W'(RST_MIN);
  localparam logic [CNT_W-1:0] PRES_DLY_C  = CNT_W'(PRES_DLY);
  localparam logic [CNT_W-1:0] PRES_LEN_C  = CNT_W'(PRES_LEN);
  localparam logic [CNT_W-1:0] SAMPLE_PT_C = CNT_W'(SAMPLE_PT);
  localparam logic [CNT_W-1:0] RD_HOLD_C   = CNT_W'(RD_HOLD);
  // The slot phase must cover both the write sample point and the read hold.
  localparam logic [CNT_W-1:0] SLOT_END_C  =
    (SAMPLE_PT > RD_HOLD) ? SAMPLE_PT_C : RD_HOLD_C;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s2_q, s_prev_q;
  logic             drive_low_q, drive_low_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_pending_q, tx_pending_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic             rx_bit_q, rx_bit_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             tx_done_q, tx_done_d;
  logic             reset_seen_q, reset_seen_d;
  logic             fall;

  // Synchroniser plus previous-value flop; idle level of the line is high.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      s_prev_q <= 1'b1;
    end else begin
      s1_q     <= bus;
      s2_q     <= s1_q;
      s_prev_q <= s2_q;
    end
  end

  assign fall = s_prev_q & ~s2_q;

  // Next-state, counter, shift registers and pulse outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    drive_low_d  = 1'b0;
    tx_shift_d   = tx_shift_q;
    tx_pending_d = tx_pending_q;
    tx_idx_d     = tx_idx_q;
    rx_shift_d   = rx_shift_q;
    rx_idx_d     = rx_idx_q;
    rx_bit_d     = rx_bit_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    tx_done_d    = 1'b0;
    reset_seen_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tx_load && !tx_pending_q) begin
          tx_shift_d   = tx_data;
          tx_pending_d = 1'b1;
          tx_idx_d     = 3'd0;
        end
        if (fall) begin
          state_d     = SLOT;
          cnt_d       = CNT_ONE;
          // Look ahead so the read-0 drive starts on the first SLOT cycle,
          // including the case where the byte is loaded on this very edge.
          drive_low_d = tx_pending_d && !tx_shift_d[tx_idx_d];
        end
      end

      SLOT: begin
        cnt_d = cnt_q + CNT_ONE;
        // Drive covers cnt = 1..RD_HOLD, i.e. exactly RD_HOLD cycles.
        if (tx_pending_q && !tx_shift_q[tx_idx_q] && (cnt_q < RD_HOLD_C))
          drive_low_d = 1'b1;
        if (!tx_pending_q && (cnt_q == SAMPLE_PT_C))
          rx_bit_d = s2_q;
        if (cnt_q >= SLOT_END_C)
          state_d = WAIT_HIGH;
      end

      WAIT_HIGH: begin
        // The line may already be high here (short write-1 / read-1 slot),
        // so the release is taken from the synced level, not a fresh edge.
        if (s2_q) begin
          if (cnt_q >= RST_MIN_C) begin
            rx_shift_d   = '0;
            rx_idx_d     = 3'd0;
            tx_pending_d = 1'b0;
            tx_idx_d     = 3'd0;
            reset_seen_d = 1'b1;
            state_d      = PRES_WAIT;
            cnt_d        = CNT_ONE;
          end else begin
            if (tx_pending_q) begin
              tx_idx_d = tx_idx_q + 3'd1;
              if (tx_idx_q == 3'd7) begin
                tx_pending_d = 1'b0;
                tx_done_d    = 1'b1;
              end
            end else begin
              rx_shift_d = {rx_bit_q, rx_shift_q[7:1]};
              rx_idx_d   = rx_idx_q + 3'd1;
              if (rx_idx_q == 3'd7) begin
                rx_data_d  = rx_shift_d;
                rx_valid_d = 1'b1;
              end
            end
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      PRES_WAIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q >= PRES_DLY_C) begin
          state_d     = PRES_DRIVE;
          cnt_d       = CNT_ONE;
          drive_low_d = 1'b1;
        end
      end

      PRES_DRIVE: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q >= PRES_LEN_C) begin
          state_d = PRES_END;
          cnt_d   = '0;
        end else begin
          drive_low_d = 1'b1;
        end
      end

      PRES_END: begin
        if (s2_q) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State register; disable behaves like reset but keeps the last rx byte.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      drive_low_q  <= 1'b0;
      tx_shift_q   <= '0;
      tx_pending_q <= 1'b0;
      tx_idx_q     <= 3'd0;
      rx_shift_q   <= '0;
      rx_idx_q     <= 3'd0;
      rx_bit_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      tx_done_q    <= 1'b0;
      reset_seen_q <= 1'b0;
      if (reset) rx_data_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drive_low_q  <= drive_low_d;
      tx_shift_q   <= tx_shift_d;
      tx_pending_q <= tx_pending_d;
      tx_idx_q     <= tx_idx_d;
      rx_shift_q   <= rx_shift_d;
      rx_idx_q     <= rx_idx_d;
      rx_bit_q     <= rx_bit_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      tx_done_q    <= tx_done_d;
      reset_seen_q <= reset_seen_d;
    end
  end

  assign bus        = drive_low_q ? 1'b0 : 1'bz;
  assign tx_ready   = !tx_pending_q && (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign tx_done    = tx_done_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign reset_seen = reset_seen_q;

endmodule

// File: tb/tb_ow_responder.sv
// Bench for ow_responder: a behavioural one-wire master plus a byte-level
// reference model of what the responder should receive and return.
module tb_ow_responder;
  localparam int RD_HOLD  = 30;
  localparam int PRES_DLY = 30;
  localparam int PRES_LEN = 120;

  logic       clk = 1'b0;
  logic       reset, en, m_low, tx_load;
  logic [7:0] tx_data;
  wire        bus;
  logic       tx_ready, tx_done, rx_valid, reset_seen, busy;
  logic [7:0] rx_data;

  pullup (bus);
  assign bus = m_low ? 1'b0 : 1'bz;

  ow_responder dut (
    .clk(clk), .reset(reset), .en(en), .bus(bus),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .tx_done(tx_done), .rx_data(rx_data), .rx_valid(rx_valid),
    .reset_seen(reset_seen), .busy(busy)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  int n_rxv = 0, n_txd = 0;
  logic [7:0] last_rx = 8'h00;

  // Reference model state
  int         exp_rxv = 0, exp_txd = 0;
  logic [7:0] exp_rx = 8'h00;
  bit         m_pending = 0;
  logic [7:0] m_tx = 8'h00;
  int         m_idx = 0;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) begin n_rxv++; last_rx = rx_data; end
      if (tx_done) n_txd++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, want);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic write_bit(input bit b);
    m_low = 1'b1;
    repeat (b ? 5 : 60) tick();
    m_low = 1'b0;
    repeat (b ? 75 : 20) tick();
  endtask

  task automatic write_byte(input logic [7:0] b);
    for (int i = 0; i < 7; i++) write_bit(b[i]);
    chk("rxv_early", n_rxv, exp_rxv);
    write_bit(b[7]);
    exp_rxv++;
    exp_rx = b;
    chk("rxv_cnt", n_rxv, exp_rxv);
    chk("rx_data", rx_data, exp_rx);
  endtask

  task automatic load(input logic [7:0] b);
    chk("tx_ready_pre", tx_ready, !m_pending);
    if (!m_pending) begin m_pending = 1; m_tx = b; m_idx = 0; end
    tx_data = b; tx_load = 1'b1;
    tick();
    tx_load = 1'b0;
  endtask

  // One master read slot: 2-cycle low, sample at 15, count responder lows.
  task automatic read_slot(output bit v);
    int lows, want_low;
    want_low = (m_pending && !m_tx[m_idx]) ? RD_HOLD : 0;
    lows = 0; v = 1'b1;
    m_low = 1'b1;
    tick(); tick();
    m_low = 1'b0;
    for (int t = 3; t < 80; t++) begin
      tick();
      if (t == 15) v = (bus !== 1'b0);
      if (bus === 1'b0) lows++;
    end
    chk("rd_hold", lows, want_low);
    if (m_pending) begin
      m_idx++;
      if (m_idx == 8) begin m_pending = 0; m_idx = 0; exp_txd++; end
    end
  endtask

  task automatic read_byte;
    logic [7:0] got, want;
    bit v;
    want = m_tx;
    for (int i = 0; i < 8; i++) begin read_slot(v); got[i] = v; end
    chk("rd_byte", got, want);
    chk("txd_cnt", n_txd, exp_txd);
    chk("tx_ready_post", tx_ready, 1);
  endtask

  task automatic master_reset(input int len);
    bit found;
    int d, l;
    m_low = 1'b1;
    repeat (len) tick();
    m_low = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (reset_seen) found = 1;
    end
    chk("rst_seen", found, 1);
    m_pending = 0; m_idx = 0;
    tick(); d = 1;
    chk("rst_seen_pulse", reset_seen, 0);
    while (bus !== 1'b0 && d < 100) begin tick(); d++; end
    chk("pres_dly", d, PRES_DLY);
    l = 0;
    while (bus === 1'b0 && l < 200) begin tick(); l++; end
    chk("pres_len", l, PRES_LEN);
    d = 0;
    while (busy && d < 20) begin tick(); d++; end
    chk("pres_idle", busy, 0);
  endtask

  initial begin
    logic [7:0] b;
    bit v;
    reset = 1'b1; en = 1'b1; m_low = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
    repeat (3) tick();
    chk("rst_bus", bus, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_reset_seen", reset_seen, 0);
    reset = 1'b0;
    repeat (5) tick();

    // Reset and presence
    master_reset(500);
    repeat (10) tick();

    // Writes
    write_byte(8'hA5);
    for (int k = 0; k < 2; k++) write_byte(8'($urandom));

    // Reads
    load(8'h3C);
    read_byte();
    for (int k = 0; k < 2; k++) begin
      load(8'($urandom));
      read_byte();
    end

    // Reset mid-byte: partial byte discarded
    for (int k = 0; k < 3; k++) write_bit(1'($urandom));
    master_reset(600);
    chk("rxv_after_rst", n_rxv, exp_rxv);
    write_byte(8'h0F);

    // Second load ignored while pending
    b = 8'($urandom);
    load(b);
    chk("tx_ready_busy", tx_ready, 0);
    load(8'hFF);
    read_byte();

    // Bus reset while a tx byte is pending: no tx_done, pending dropped
    load(8'($urandom));
    read_slot(v); read_slot(v);
    master_reset(600);
    chk("txd_after_rst", n_txd, exp_txd);
    chk("tx_ready_after_rst", tx_ready, 1);

    // Drop enable during the presence drive
    m_low = 1'b1;
    repeat (500) tick();
    m_low = 1'b0;
    repeat (45) tick();
    chk("pres_drive_low", bus, 0);
    en = 1'b0;
    tick();
    chk("en_bus", bus, 1);
    chk("en_busy", busy, 0);
    chk("en_rx_hold", rx_data, exp_rx);
    en = 1'b1;
    repeat (5) tick();

    // Reset during a read-0 drive
    load(8'($urandom) & 8'hFE);
    m_low = 1'b1;
    tick(); tick();
    m_low = 1'b0;
    repeat (3) tick();
    chk("slot_drive_low", bus, 0);
    reset = 1'b1;
    tick();
    chk("sr_bus", bus, 1);
    chk("sr_rx_data", rx_data, 0);
    chk("sr_tx_ready", tx_ready, 1);
    chk("sr_busy", busy, 0);
    chk("sr_tx_done", tx_done, 0);
    chk("sr_rx_valid", rx_valid, 0);
    chk("sr_reset_seen", reset_seen, 0);
    reset = 1'b0;
    m_pending = 0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
